// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle datapath: fetch/decode/execute/memory/write-back sequencing.
// Moore outputs are registered alongside state; IRWrite/PCWrite in FETCH and illegal_op are input-qualified.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic [3:0] state,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
  } ctl_t;

  state_t state_q;
  state_t state_nxt;
  ctl_t   ctl_q;
  logic   legal_op;

  // Pure Moore decode; loaded with the next state's value so outputs are registered.
  function automatic ctl_t decode(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_RWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign legal_op = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);

  always_comb begin
    state_nxt = S_FETCH;
    case (state_q)
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          OP_ADDI:      state_nxt = S_ADDIEX;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_nxt = S_RWB;
      S_ADDIEX: state_nxt = S_ADDIWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ctl_q   <= decode(S_FETCH);
    end else begin
      state_q <= state_nxt;
      ctl_q   <= decode(state_nxt);
    end
  end

  // Reset gates every output combinationally so nothing fires during an aborted instruction.
  assign ALUOp       = rst ? 2'b00 : ctl_q.alu_op;
  assign ALUSrcA     = !rst && ctl_q.alu_src_a;
  assign ALUSrcB     = rst ? 2'b00 : ctl_q.alu_src_b;
  assign PCSource    = rst ? 2'b00 : ctl_q.pc_source;
  assign PCWriteCond = !rst && ctl_q.pc_write_cond;
  assign IorD        = !rst && ctl_q.iord;
  assign MemRead     = !rst && ctl_q.mem_read;
  assign MemWrite    = !rst && ctl_q.mem_write;
  assign MemtoReg    = !rst && ctl_q.mem_to_reg;
  assign RegDst      = !rst && ctl_q.reg_dst;
  assign RegWrite    = !rst && ctl_q.reg_write;
  assign IRWrite     = !rst && (state_q == S_FETCH) && mem_ready;
  assign PCWrite     = !rst && (ctl_q.pc_write || ((state_q == S_FETCH) && mem_ready));
  assign illegal_op  = !rst && (state_q == S_DECODE) && !legal_op;
  assign state       = rst ? 4'd0 : state_q;

endmodule
